// File: rtl/grid_pkg.sv
// Shared colour type, palette and grid geometry helpers for the grid renderer.
package grid_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned COLOR_W = 12;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t BLACK          = 12'h000;
   localparam color_t GAP_COLOR      = 12'h7FF;
   localparam color_t IND_COLOR      = 12'hDA0;
   localparam color_t BORDER_DEFAULT = 12'h606;
   localparam color_t BORDER_ERROR   = 12'hA30;

   function automatic int unsigned pitch(input int unsigned cell_w, input int unsigned gap_w);
      return cell_w + gap_w;
   endfunction

   // Full grid span including the closing gap line.
   function automatic int unsigned extent(input int unsigned n, input int unsigned cell_w,
                                          input int unsigned gap_w);
      return n * pitch(cell_w, gap_w) + gap_w;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/grid_axis_decode.sv
// One-axis decode of a pixel coordinate into cell index, gap flag and indicator-bar hits.
module grid_axis_decode
   import grid_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned ORIGIN   = 110,
   parameter int unsigned CELL_W   = 100,
   parameter int unsigned GAP_W    = 4,
   parameter int unsigned IND_LEN  = 11,
   parameter int unsigned IND_THK  = 4,
   localparam int unsigned IW      = idx_width(N)
) (
   input  logic [COORD_W-1:0] coord,
   output logic               in_grid_c,
   output logic               is_gap_c,
   output logic [IW-1:0]      index_c,
   output logic               in_ind_band_c,
   output logic               on_ind_center_c
);

   localparam int unsigned P       = pitch(CELL_W, GAP_W);
   localparam int unsigned SPAN    = N * P;
   localparam int unsigned EXT     = extent(N, CELL_W, GAP_W);
   localparam int unsigned BAND_LO = ORIGIN - IND_THK - IND_LEN;
   localparam int unsigned BAND_HI = ORIGIN - IND_THK;
   localparam int unsigned HALF    = IND_THK / 2;
   localparam int unsigned CTR0    = ORIGIN + GAP_W + CELL_W / 2;

   // Comparator chain replaces l/P; the last index also absorbs the closing gap.
   always_comb begin
      int unsigned c;
      int unsigned l;
      int unsigned base;
      c               = 32'(coord);
      l               = c - ORIGIN;
      base            = 0;
      index_c         = '0;
      on_ind_center_c = 1'b0;
      for (int unsigned i = 1; i < N; i++) begin
         if (l >= i * P) begin
            index_c = IW'(i);
            base    = i * P;
         end
      end
      in_grid_c     = (c >= ORIGIN) && (c < ORIGIN + EXT);
      is_gap_c      = ((l - base) < GAP_W) || (l >= SPAN);
      in_ind_band_c = (c >= BAND_LO) && (c < BAND_HI);
      for (int unsigned i = 0; i < N; i++) begin
         if ((c + HALF >= CTR0 + i * P) && (c < CTR0 + i * P + HALF))
            on_ind_center_c = 1'b1;
      end
   end

endmodule

// File: rtl/grid_renderer.sv
// Two-stage VGA colour generator for a gapped cell grid with indicator bars and a blinking error border.
module grid_renderer
   import grid_pkg::*;
#(
   parameter int unsigned ROWS         = 4,
   parameter int unsigned COLS         = 4,
   parameter int unsigned CELL_W       = 100,
   parameter int unsigned GAP_W        = 4,
   parameter int unsigned ORIGIN_X     = 110,
   parameter int unsigned ORIGIN_Y     = 30,
   parameter int unsigned IND_LEN      = 11,
   parameter int unsigned IND_THK      = 4,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [COORD_W-1:0]        x,
   input  logic [COORD_W-1:0]        y,
   input  logic                      videoOn,
   input  logic                      frameStart,
   input  logic [ROWS-1:0]           row,
   input  logic [COLS-1:0]           col,
   input  logic [ROWS*COLS*12-1:0]   cells,
   input  logic                      error,
   output logic [COLOR_W-1:0]        rgb
);

   localparam int unsigned RW    = idx_width(ROWS);
   localparam int unsigned CW    = idx_width(COLS);
   localparam int unsigned CNT_W = idx_width(BLINK_FRAMES);

   if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || BLINK_FRAMES < 1 ||
       ORIGIN_X < IND_THK + IND_LEN || ORIGIN_Y < IND_THK + IND_LEN ||
       ORIGIN_X + extent(COLS, CELL_W, GAP_W) > 640 ||
       ORIGIN_Y + extent(ROWS, CELL_W, GAP_W) > 480) begin : g_geom_bad
      $error("grid_renderer: grid geometry does not fit the 640x480 frame");
   end

   logic          x_in_c, x_gap_c, x_band_c, x_ctr_c;
   logic          y_in_c, y_gap_c, y_band_c, y_ctr_c;
   logic [CW-1:0] x_idx_c;
   logic [RW-1:0] y_idx_c;

   grid_axis_decode #(
      .N(COLS), .ORIGIN(ORIGIN_X), .CELL_W(CELL_W), .GAP_W(GAP_W),
      .IND_LEN(IND_LEN), .IND_THK(IND_THK)
   ) u_x_decode (
      .coord(x), .in_grid_c(x_in_c), .is_gap_c(x_gap_c), .index_c(x_idx_c),
      .in_ind_band_c(x_band_c), .on_ind_center_c(x_ctr_c)
   );

   grid_axis_decode #(
      .N(ROWS), .ORIGIN(ORIGIN_Y), .CELL_W(CELL_W), .GAP_W(GAP_W),
      .IND_LEN(IND_LEN), .IND_THK(IND_THK)
   ) u_y_decode (
      .coord(y), .in_grid_c(y_in_c), .is_gap_c(y_gap_c), .index_c(y_idx_c),
      .in_ind_band_c(y_band_c), .on_ind_center_c(y_ctr_c)
   );

   logic          vid_q;
   logic          x_in_q, x_gap_q, x_band_q, x_ctr_q;
   logic          y_in_q, y_gap_q, y_band_q, y_ctr_q;
   logic [CW-1:0] x_idx_q;
   logic [RW-1:0] y_idx_q;

   // Stage 1: registered axis decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_q    <= 1'b0;
         x_in_q   <= 1'b0;
         x_gap_q  <= 1'b0;
         x_band_q <= 1'b0;
         x_ctr_q  <= 1'b0;
         x_idx_q  <= '0;
         y_in_q   <= 1'b0;
         y_gap_q  <= 1'b0;
         y_band_q <= 1'b0;
         y_ctr_q  <= 1'b0;
         y_idx_q  <= '0;
      end else begin
         vid_q    <= videoOn;
         x_in_q   <= x_in_c;
         x_gap_q  <= x_gap_c;
         x_band_q <= x_band_c;
         x_ctr_q  <= x_ctr_c;
         x_idx_q  <= x_idx_c;
         y_in_q   <= y_in_c;
         y_gap_q  <= y_gap_c;
         y_band_q <= y_band_c;
         y_ctr_q  <= y_ctr_c;
         y_idx_q  <= y_idx_c;
      end
   end

   logic             err_latched;
   logic             phase;
   logic [CNT_W-1:0] frame_cnt;

   // Blink state only moves on frame boundaries so the border is steady within a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_latched <= 1'b0;
         phase       <= 1'b0;
         frame_cnt   <= '0;
      end else if (frameStart) begin
         err_latched <= error;
         if (!error) begin
            phase     <= 1'b0;
            frame_cnt <= '0;
         end else if (!err_latched) begin
            phase     <= 1'b1;
            frame_cnt <= '0;
         end else if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            phase     <= ~phase;
            frame_cnt <= '0;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   color_t border_c;
   color_t color_c;

   // Stage 2 colour priority: blanking, grid, column bars, row bars, border.
   always_comb begin
      int unsigned sel;
      sel      = 32'(y_idx_q) * COLS + 32'(x_idx_q);
      border_c = (err_latched && phase) ? BORDER_ERROR : BORDER_DEFAULT;
      color_c  = border_c;
      if (!vid_q)
         color_c = BLACK;
      else if (x_in_q && y_in_q)
         color_c = (x_gap_q || y_gap_q) ? GAP_COLOR : cells[12*sel +: 12];
      else if (y_band_q && x_ctr_q && col[x_idx_q])
         color_c = IND_COLOR;
      else if (x_band_q && y_ctr_q && row[y_idx_q])
         color_c = IND_COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) rgb <= BLACK;
      else       rgb <= color_c;
   end

endmodule

// File: tb/tb_grid_renderer.sv
// Directed checks of grid_renderer: latency, grid/gap/indicator decode, blinking border and reset.
module tb_grid_renderer;

   logic         clk = 1'b0;
   logic         reset;
   logic [9:0]   x, y;
   logic         videoOn, frameStart, error;
   logic [3:0]   row_a, col_a;
   logic [1:0]   row_b;
   logic [7:0]   col_b;
   logic [191:0] cells_a, cells_b;
   logic [11:0]  rgb_a, rgb_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   grid_renderer #(.BLINK_FRAMES(2)) dut_a (
      .clk(clk), .reset(reset), .x(x), .y(y), .videoOn(videoOn), .frameStart(frameStart),
      .row(row_a), .col(col_a), .cells(cells_a), .error(error), .rgb(rgb_a)
   );

   grid_renderer #(.ROWS(2), .COLS(8), .CELL_W(50)) dut_b (
      .clk(clk), .reset(reset), .x(x), .y(y), .videoOn(videoOn), .frameStart(frameStart),
      .row(row_b), .col(col_b), .cells(cells_b), .error(error), .rgb(rgb_b)
   );

   task automatic put(input int px, input int py, input logic v);
      @(negedge clk);
      x       = 10'(px);
      y       = 10'(py);
      videoOn = v;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      @(negedge clk);
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
   endtask

   task automatic check_a(input string name, input logic [11:0] exp);
      n_tests++;
      if (rgb_a !== exp) begin
         n_fail++;
         $display("FAIL %s: rgb=%h expected %h", name, rgb_a, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      put(200, 100, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_a("reset_rgb", 12'h000);
      n_tests++;
      if (rgb_b !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_rgb_b: rgb=%h expected 000", rgb_b);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check_a("post_reset_cycle1", 12'h000);
      @(posedge clk); #1;
      check_a("post_reset_cycle2", 12'hF00);
   endtask

   task automatic test_latency();
      put(110, 100, 1'b1);
      @(posedge clk); #1;
      check_a("latency_gap_c1", 12'hF00);
      @(posedge clk); #1;
      check_a("latency_gap_c2", 12'h7FF);
      put(200, 100, 1'b1);
      @(posedge clk); #1;
      check_a("latency_cell_c1", 12'h7FF);
      @(posedge clk); #1;
      check_a("latency_cell_c2", 12'hF00);
      put(332, 356, 1'b1);
      settle();
      check_a("cell_3_2", 12'h0C3);
      put(529, 100, 1'b1);
      settle();
      check_a("last_gap_x", 12'h7FF);
      put(530, 100, 1'b1);
      settle();
      check_a("right_of_grid", 12'h606);
   endtask

   task automatic test_col_ind();
      col_a = 4'b0010;
      put(267, 20, 1'b1);
      settle();
      check_a("col_ind_on", 12'hDA0);
      put(269, 20, 1'b1);
      settle();
      check_a("col_ind_last_px", 12'hDA0);
      put(270, 20, 1'b1);
      settle();
      check_a("col_ind_past_end", 12'h606);
      put(267, 20, 1'b1);
      col_a = 4'b0000;
      settle();
      check_a("col_ind_disabled", 12'h606);
      col_a = 4'b1111;
      put(265, 20, 1'b1);
      settle();
      check_a("col_ind_off_center", 12'h606);
      col_a = 4'b0000;
   endtask

   task automatic test_row_ind();
      row_a = 4'b0001;
      put(100, 83, 1'b1);
      settle();
      check_a("row_ind_on", 12'hDA0);
      put(100, 82, 1'b1);
      settle();
      check_a("row_ind_first_px", 12'hDA0);
      put(100, 86, 1'b1);
      settle();
      check_a("row_ind_past_end", 12'h606);
      put(106, 83, 1'b1);
      settle();
      check_a("row_ind_clearance", 12'h606);
      row_a = 4'b0000;
   endtask

   task automatic test_video_off();
      put(200, 100, 1'b0);
      settle();
      check_a("video_off", 12'h000);
   endtask

   task automatic test_sweep();
      logic [11:0] exp;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 8; c++) begin
            exp = 12'((r * 8 + c) * 37 + 257);
            put(139 + 54 * c, 59 + 54 * r, 1'b1);
            settle();
            n_tests++;
            if (rgb_b !== exp) begin
               n_fail++;
               $display("FAIL sweep_r%0d_c%0d: rgb=%h expected %h", r, c, rgb_b, exp);
            end
         end
      end
      put(546, 59, 1'b1);
      settle();
      n_tests++;
      if (rgb_b !== 12'h606) begin
         n_fail++;
         $display("FAIL sweep_right_edge: rgb=%h expected 606", rgb_b);
      end
      put(545, 59, 1'b1);
      settle();
      n_tests++;
      if (rgb_b !== 12'h7FF) begin
         n_fail++;
         $display("FAIL sweep_last_gap: rgb=%h expected 7ff", rgb_b);
      end
      put(139, 142, 1'b1);
      settle();
      n_tests++;
      if (rgb_b !== 12'h606) begin
         n_fail++;
         $display("FAIL sweep_bottom_edge: rgb=%h expected 606", rgb_b);
      end
   endtask

   task automatic test_blink();
      logic [11:0] seq [5];
      seq = '{12'hA30, 12'hA30, 12'h606, 12'h606, 12'hA30};
      put(5, 5, 1'b1);
      error = 1'b0;
      frame_pulse();
      settle();
      check_a("blink_idle", 12'h606);
      error = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_a("blink_midframe_rise", 12'h606);
      for (int f = 0; f < 5; f++) begin
         frame_pulse();
         settle();
         n_tests++;
         if (rgb_a !== seq[f]) begin
            n_fail++;
            $display("FAIL blink_frame%0d: rgb=%h expected %h", f + 1, rgb_a, seq[f]);
         end
      end
      @(negedge clk);
      error = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_a("blink_midframe_fall", 12'hA30);
      frame_pulse();
      settle();
      check_a("blink_dropped", 12'h606);
      frame_pulse();
      settle();
      check_a("blink_dropped_next", 12'h606);
   endtask

   task automatic test_reset_mid();
      error = 1'b1;
      put(5, 5, 1'b1);
      frame_pulse();
      settle();
      check_a("pre_reset_err", 12'hA30);
      put(200, 100, 1'b1);
      settle();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_a("reset_midline", 12'h000);
      put(5, 5, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      settle();
      check_a("reset_cleared_blink", 12'h606);
      frame_pulse();
      settle();
      check_a("err_after_reset", 12'hA30);
      @(negedge clk);
      reset      = 1'b1;
      frameStart = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      frameStart = 1'b0;
      settle();
      check_a("reset_beats_frame", 12'h606);
   endtask

   initial begin
      reset      = 1'b1;
      x          = '0;
      y          = '0;
      videoOn    = 1'b0;
      frameStart = 1'b0;
      error      = 1'b0;
      row_a      = '0;
      col_a      = '0;
      row_b      = '0;
      col_b      = '0;
      cells_a    = '0;
      for (int i = 0; i < 16; i++) cells_a[12*i +: 12] = 12'h111;
      cells_a[11:0]      = 12'hF00;
      cells_a[12*14 +: 12] = 12'h0C3;
      for (int i = 0; i < 16; i++) cells_b[12*i +: 12] = 12'(i * 37 + 257);

      test_reset();
      test_latency();
      test_col_ind();
      test_row_ind();
      test_video_off();
      test_sweep();
      test_blink();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
